// File: rtl/axi_lite_slave_frontend.sv
// axi_lite_slave_frontend
//   Bus-facing half of an AXI4-Lite slave. Terminates the AXI handshakes in
//   the axi_clk domain and turns them into pushes to the AW/W/AR request FIFOs
//   and pops from the R/B response FIFOs. The SRAM-side controller drains the
//   same FIFOs on its own clock.
//   Each direction limits the number of accepted-but-unresponded transactions
//   to MAX_OUTSTANDING.
//
// Optional feature macro: AXIL_FE_RESP_REG_EN
//   defined   -> R and B responses come from one-entry output registers
//   undefined -> R and B responses pass straight through from the FIFOs
//
// Ports
//   axi_clk, axi_rst         clock, synchronous active-high reset
//   s_axi_aw*/w*/b*/ar*/r*   AXI4-Lite slave channels
//   aw_fifo_*, w_fifo_*      request FIFO write sides (W entry = {wstrb, wdata})
//   ar_fifo_*                read request FIFO write side
//   r_fifo_*, b_fifo_*       response FIFO read sides (first-word-fall-through)
module axi_lite_slave_frontend #(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                        axi_clk,
  input  logic                                        axi_rst,
  input  logic [AXI_ADDR_WIDTH-1:0]                   s_axi_awaddr,
  input  logic                                        s_axi_awvalid,
  output logic                                        s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]                   s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]                 s_axi_wstrb,
  input  logic                                        s_axi_wvalid,
  output logic                                        s_axi_wready,
  output logic [1:0]                                  s_axi_bresp,
  output logic                                        s_axi_bvalid,
  input  logic                                        s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]                   s_axi_araddr,
  input  logic                                        s_axi_arvalid,
  output logic                                        s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]                   s_axi_rdata,
  output logic [1:0]                                  s_axi_rresp,
  output logic                                        s_axi_rvalid,
  input  logic                                        s_axi_rready,
  output logic [AXI_ADDR_WIDTH-1:0]                   aw_fifo_wdata,
  output logic                                        aw_fifo_wen,
  input  logic                                        aw_fifo_full,
  output logic [AXI_DATA_WIDTH+AXI_DATA_WIDTH/8-1:0]  w_fifo_wdata,
  output logic                                        w_fifo_wen,
  input  logic                                        w_fifo_full,
  output logic [AXI_ADDR_WIDTH-1:0]                   ar_fifo_wdata,
  output logic                                        ar_fifo_wen,
  input  logic                                        ar_fifo_full,
  input  logic [AXI_DATA_WIDTH-1:0]                   r_fifo_rdata,
  output logic                                        r_fifo_ren,
  input  logic                                        r_fifo_empty,
  input  logic [1:0]                                  b_fifo_rdata,
  output logic                                        b_fifo_ren,
  input  logic                                        b_fifo_empty
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

  logic [CW-1:0] r_aw_cnt, r_w_cnt, r_ar_cnt;
  logic          w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs;

  // A decrement with the counter already at 0 is a bus protocol violation;
  // the counter holds rather than wrapping.
  function automatic logic [CW-1:0] f_next_cnt(input logic [CW-1:0] cnt,
                                               input logic inc,
                                               input logic dec);
    logic [CW-1:0] nxt;
    nxt = cnt;
    if (inc && !dec)
      nxt = cnt + CW'(1);
    else if (!inc && dec && (cnt != '0))
      nxt = cnt - CW'(1);
    return nxt;
  endfunction

  assign s_axi_awready = !axi_rst && !aw_fifo_full && (r_aw_cnt < MAX_C);
  assign s_axi_wready  = !axi_rst && !w_fifo_full  && (r_w_cnt  < MAX_C);
  assign s_axi_arready = !axi_rst && !ar_fifo_full && (r_ar_cnt < MAX_C);

  assign w_aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_w_hs  = s_axi_wvalid  && s_axi_wready;
  assign w_ar_hs = s_axi_arvalid && s_axi_arready;
  assign w_b_hs  = s_axi_bvalid  && s_axi_bready;
  assign w_r_hs  = s_axi_rvalid  && s_axi_rready;

  assign aw_fifo_wen   = w_aw_hs;
  assign aw_fifo_wdata = s_axi_awaddr;
  assign w_fifo_wen    = w_w_hs;
  assign w_fifo_wdata  = {s_axi_wstrb, s_axi_wdata};
  assign ar_fifo_wen   = w_ar_hs;
  assign ar_fifo_wdata = s_axi_araddr;

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      r_aw_cnt <= '0;
      r_w_cnt  <= '0;
      r_ar_cnt <= '0;
    end else begin
      r_aw_cnt <= f_next_cnt(r_aw_cnt, w_aw_hs, w_b_hs);
      r_w_cnt  <= f_next_cnt(r_w_cnt,  w_w_hs,  w_b_hs);
      r_ar_cnt <= f_next_cnt(r_ar_cnt, w_ar_hs, w_r_hs);
    end
  end

  assign s_axi_rresp = 2'b00;

`ifdef AXIL_FE_RESP_REG_EN
  logic                      r_rvalid, r_bvalid;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;
  logic [1:0]                r_bresp;
  logic                      w_r_load, w_b_load;

  // Refill the output register whenever it is empty or being drained this
  // cycle, which keeps one beat per cycle under continuous ready.
  assign w_r_load = !axi_rst && !r_fifo_empty && (!r_rvalid || s_axi_rready);
  assign w_b_load = !axi_rst && !b_fifo_empty && (!r_bvalid || s_axi_bready);

  assign r_fifo_ren = w_r_load;
  assign b_fifo_ren = w_b_load;

  // Valid is masked during reset so no handshake can complete in the first
  // reset cycle, before the flops have cleared.
  assign s_axi_rvalid = r_rvalid && !axi_rst;
  assign s_axi_bvalid = r_bvalid && !axi_rst;
  assign s_axi_rdata  = r_rdata;
  assign s_axi_bresp  = r_bresp;

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else if (w_r_load) begin
      r_rvalid <= 1'b1;
      r_rdata  <= r_fifo_rdata;
    end else if (r_rvalid && s_axi_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      r_bvalid <= 1'b0;
      r_bresp  <= 2'b00;
    end else if (w_b_load) begin
      r_bvalid <= 1'b1;
      r_bresp  <= b_fifo_rdata;
    end else if (r_bvalid && s_axi_bready) begin
      r_bvalid <= 1'b0;
    end
  end
`else
  assign s_axi_rvalid = !axi_rst && !r_fifo_empty;
  assign s_axi_bvalid = !axi_rst && !b_fifo_empty;
  assign s_axi_rdata  = r_fifo_rdata;
  assign s_axi_bresp  = b_fifo_rdata;
  assign r_fifo_ren   = w_r_hs;
  assign b_fifo_ren   = w_b_hs;
`endif

endmodule
